// File: rtl/spy_arb_pkg.sv
// -----------------------------------------------------------------------------
// spy_arb_pkg
// Shared definitions for the AXI spy capture path arbiters.
//   SRC_*    : source tags used by the spy channel monitors on the push arbiter
//   rr_next  : round-robin wrap-around increment over 0..n-1 (n need not be a
//              power of two)
// -----------------------------------------------------------------------------
package spy_arb_pkg;

   localparam int SRC_AW = 0;
   localparam int SRC_W  = 1;
   localparam int SRC_AR = 2;
   localparam int SRC_R  = 3;

   // Wraps at n rather than at a power of two, so a 3-source arbiter
   // never lands on the unused index 3.
   function automatic int rr_next(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority search. Starting at ptr_i and walking upward
// modulo NUM_REQ, returns the first set bit of req_i.
// Ports:
//   req_i  [NUM_REQ] : request vector, bit i = source i
//   ptr_i  [ID_W]    : highest-priority index for this search
//   any_o            : at least one request is set
//   idx_o  [ID_W]    : index of the winner (0 when any_o=0)
// -----------------------------------------------------------------------------
module rr_pick
   import spy_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic               any_o,
   output logic [ID_W-1:0]    idx_o
);

   // Walk the ring once from the pointer; the first hit wins. A pointer
   // outside 0..NUM_REQ-1 cannot occur in normal operation, but it is folded
   // back to 0 so the search always covers every source exactly once.
   always_comb begin : pickSearch
      int  cand;
      logic found;
      any_o = |req_i;
      idx_o = '0;
      found = 1'b0;
      cand  = (int'(ptr_i) < NUM_REQ) ? int'(ptr_i) : 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_i[cand]) begin
            found = 1'b1;
            idx_o = ID_W'(cand);
         end
         cand = rr_next(cand, NUM_REQ);
      end
   end

endmodule

// File: rtl/spy_fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// spy_fifo_push_arbiter
// Shares the capture FIFO push port between NUM_REQ spy channel monitors.
// One source is picked per cycle in round-robin order, its payload is tagged
// with the source ID and pushed when the FIFO is not full. A saturating count
// of back-pressure stall cycles is kept for status readout.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   req_valid_i       : per-source valid
//   req_data_i        : packed payloads, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o       : one-hot-or-zero accept to the sources
//   fifo_full_i       : FIFO full flag
//   fifo_push_o       : FIFO push strobe
//   fifo_push_data_o  : {source id, payload}
//   grant_id_o        : accepted source id (meaningful while fifo_push_o=1)
//   stall_clr_i       : synchronous clear of the stall counter
//   stall_cnt_o       : saturating count of cycles with a valid blocked by full
// -----------------------------------------------------------------------------
module spy_fifo_push_arbiter
   import spy_arb_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int DATA_WIDTH  = 64,
   parameter  int STALL_CNT_W = 16,
   localparam int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          fifo_full_i,
   output logic                          fifo_push_o,
   output logic [DATA_WIDTH+ID_W-1:0]    fifo_push_data_o,
   output logic [ID_W-1:0]               grant_id_o,
   input  logic                          stall_clr_i,
   output logic [STALL_CNT_W-1:0]        stall_cnt_o
);

   logic [ID_W-1:0]        rrPtr_q;
   logic [ID_W-1:0]        rrPtr_d;
   logic [STALL_CNT_W-1:0] stallCnt_q;
   logic [STALL_CNT_W-1:0] stallCnt_d;
   logic                   anyValid;
   logic [ID_W-1:0]        winIdx;
   logic                   accept;
   logic                   stallEvent;
   logic [DATA_WIDTH-1:0]  payload;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) uPick (
      .req_i (req_valid_i),
      .ptr_i (rrPtr_q),
      .any_o (anyValid),
      .idx_o (winIdx)
   );

   // Accept and handshake outputs. Reset gates these combinationally so a
   // handshake in flight is dropped the moment reset rises, not at the next
   // edge. Ready is built per source by comparison with the winner so it can
   // only ever be set for a source whose valid is high.
   always_comb begin
      accept      = anyValid && !fifo_full_i && !reset;
      fifo_push_o = accept;
      grant_id_o  = accept ? winIdx : '0;
      req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready_o[i] = accept && (winIdx == ID_W'(i));
      end
   end

   // Unregistered payload mux; the source tag sits in the MSBs so the drain
   // side can demultiplex without knowing DATA_WIDTH.
   always_comb begin
      payload = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winIdx == ID_W'(i)) begin
            payload = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      fifo_push_data_o = {winIdx, payload};
   end

   // Next-state for the round-robin pointer and the stall counter. The
   // pointer moves to just past the winner, so the source that was served
   // becomes lowest priority. Clear beats increment; all-ones is sticky.
   assign stallEvent = anyValid && fifo_full_i;

   always_comb begin
      rrPtr_d    = rrPtr_q;
      stallCnt_d = stallCnt_q;
      if (accept) begin
         rrPtr_d = ID_W'(rr_next(int'(winIdx), NUM_REQ));
      end
      if (stall_clr_i) begin
         stallCnt_d = '0;
      end else if (stallEvent && !(&stallCnt_q)) begin
         stallCnt_d = stallCnt_q + STALL_CNT_W'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rrPtr_q    <= '0;
         stallCnt_q <= '0;
      end else begin
         rrPtr_q    <= rrPtr_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   assign stall_cnt_o = stallCnt_q;

   // Requester contract: a pending item (valid without ready) must stay
   // presented, unchanged, until it is accepted.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gContract
      holdUntilReady : assert property (@(posedge clk) disable iff (reset)
         (req_valid_i[gi] && !req_ready_o[gi]) |=>
            (req_valid_i[gi] && $stable(req_data_i[gi*DATA_WIDTH +: DATA_WIDTH])));
   end

   // Never push into a full FIFO.
   noPushWhenFull : assert property (@(posedge clk) disable iff (reset)
      fifo_full_i |-> !fifo_push_o);

endmodule

// File: tb/tb_spy_fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spy_fifo_push_arbiter
// Two instances: the default 4-source/64-bit/16-bit-counter build, and a
// 3-source/8-bit/4-bit-counter build for the non-power-of-two wrap and
// counter saturation. A behavioural round-robin model predicts every output.
// -----------------------------------------------------------------------------
module tb_spy_fifo_push_arbiter;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   logic [3:0]   validA;
   logic [255:0] dataA;
   logic         fullA;
   logic         clrA;
   logic [3:0]   readyA;
   logic         pushA;
   logic [65:0]  pushDataA;
   logic [1:0]   grantA;
   logic [15:0]  stallA;

   logic [2:0]   validB;
   logic [23:0]  dataB;
   logic         fullB;
   logic         clrB;
   logic [2:0]   readyB;
   logic         pushB;
   logic [9:0]   pushDataB;
   logic [1:0]   grantB;
   logic [3:0]   stallB;

   int checkCount  = 0;
   int errorCount  = 0;
   int ptrA        = 0;
   int ptrB        = 0;
   int stallModelA = 0;
   int stallModelB = 0;
   logic [3:0] pendA = '0;

   always #5 clk = ~clk;

   spy_fifo_push_arbiter #(
      .NUM_REQ(4), .DATA_WIDTH(64), .STALL_CNT_W(16)
   ) dutA (
      .clk(clk), .reset(reset),
      .req_valid_i(validA), .req_data_i(dataA), .req_ready_o(readyA),
      .fifo_full_i(fullA), .fifo_push_o(pushA), .fifo_push_data_o(pushDataA),
      .grant_id_o(grantA), .stall_clr_i(clrA), .stall_cnt_o(stallA)
   );

   spy_fifo_push_arbiter #(
      .NUM_REQ(3), .DATA_WIDTH(8), .STALL_CNT_W(4)
   ) dutB (
      .clk(clk), .reset(reset),
      .req_valid_i(validB), .req_data_i(dataB), .req_ready_o(readyB),
      .fifo_full_i(fullB), .fifo_push_o(pushB), .fifo_push_data_o(pushDataB),
      .grant_id_o(grantB), .stall_clr_i(clrB), .stall_cnt_o(stallB)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Round-robin rule: first valid source at or after ptr, modulo n.
   function automatic int rrWinner(input logic [7:0] valid, input int ptr, input int n);
      for (int k = 0; k < n; k++) begin
         if (valid[(ptr + k) % n]) return (ptr + k) % n;
      end
      return -1;
   endfunction

   // Compare instance A against the model, then advance the model by the
   // posedge that is about to happen.
   task automatic checkA();
      int         w;
      logic       acc;
      logic [3:0] expReady;
      logic [1:0] wId;
      w   = rrWinner({4'b0, validA}, ptrA, 4);
      acc = (w >= 0) && !fullA;
      expReady = '0;
      if (acc) expReady[w] = 1'b1;
      checkOutput("A push", pushA, acc);
      checkOutput("A ready", readyA, expReady);
      checkOutput("A stall", stallA, stallModelA);
      if (acc) begin
         wId = w[1:0];
         checkOutput("A grant", grantA, w);
         checkOutput("A data", pushDataA, {wId, dataA[w*64 +: 64]});
         ptrA = (w + 1) % 4;
      end
      pendA = validA & ~expReady;
      if (clrA) stallModelA = 0;
      else if (|validA && fullA && stallModelA < 65535) stallModelA++;
   endtask

   task automatic checkB();
      int         w;
      logic       acc;
      logic [2:0] expReady;
      logic [1:0] wId;
      w   = rrWinner({5'b0, validB}, ptrB, 3);
      acc = (w >= 0) && !fullB;
      expReady = '0;
      if (acc) expReady[w] = 1'b1;
      checkOutput("B push", pushB, acc);
      checkOutput("B ready", readyB, expReady);
      checkOutput("B stall", stallB, stallModelB);
      if (acc) begin
         wId = w[1:0];
         checkOutput("B grant", grantB, w);
         checkOutput("B data", pushDataB, {wId, dataB[w*8 +: 8]});
         ptrB = (w + 1) % 3;
      end
      if (clrB) stallModelB = 0;
      else if (|validB && fullB && stallModelB < 15) stallModelB++;
   endtask

   // Called on a negedge: drive inputs, let the combinational path settle,
   // compare. The caller advances with nextCycle().
   task automatic applyStimulus(input logic [3:0] v, input logic [255:0] d,
                                input logic f, input logic c);
      validA = v; dataA = d; fullA = f; clrA = c;
      #1;
      checkA();
   endtask

   task automatic applyStimulusB(input logic [2:0] v, input logic [23:0] d,
                                 input logic f, input logic c);
      validB = v; dataB = d; fullB = f; clrB = c;
      #1;
      checkB();
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   // Reset for one posedge with all sources idle; returns on the release negedge.
   task automatic doReset();
      reset  = 1'b1;
      validA = '0; fullA = 1'b0; clrA = 1'b0;
      validB = '0; fullB = 1'b0; clrB = 1'b0;
      ptrA = 0; ptrB = 0; stallModelA = 0; stallModelB = 0; pendA = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [255:0] d;
      logic [3:0]   v;

      // Reset forces the handshake outputs low even with everything valid.
      validA = 4'b1111; dataA = {8{$urandom}}; fullA = 1'b0; clrA = 1'b0;
      validB = 3'b111;  dataB = 24'hA5C3E1;     fullB = 1'b0; clrB = 1'b0;
      #1;
      checkOutput("rst A push", pushA, 1'b0);
      checkOutput("rst A ready", readyA, 4'b0);
      checkOutput("rst A grant", grantA, 2'd0);
      checkOutput("rst A stall", stallA, 16'd0);
      checkOutput("rst B push", pushB, 1'b0);
      checkOutput("rst B ready", readyB, 3'b0);
      @(negedge clk);
      validB = '0;
      reset  = 1'b0;

      // All four valid: strict rotation 0,1,2,3,0,1,2,3 with tag in the MSBs.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(4'b1111, dataA, 1'b0, 1'b0);
         checkOutput("A rr seq", grantA, i % 4);
         checkOutput("A tag", pushDataA[65:64], i % 4);
         nextCycle();
      end

      // Move the pointer to 2, then 0011 wraps to 0 and then serves 1.
      doReset();
      d = {8{$urandom}};
      applyStimulus(4'b0001, d, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(4'b0010, d, 1'b0, 1'b0);
      checkOutput("A ptr setup", grantA, 2'd1);
      nextCycle();
      applyStimulus(4'b0011, d, 1'b0, 1'b0);
      checkOutput("A wrap to 0", grantA, 2'd0);
      nextCycle();
      applyStimulus(4'b0011, d, 1'b0, 1'b0);
      checkOutput("A then 1", grantA, 2'd1);
      nextCycle();
      applyStimulus(4'b0101, d, 1'b0, 1'b0);
      checkOutput("A ptr is 2", grantA, 2'd2);
      nextCycle();

      // Back-pressure: five full cycles with source 2 waiting, then release.
      doReset();
      d = {8{$urandom}};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b0100, d, 1'b1, 1'b0);
         checkOutput("A full no push", pushA, 1'b0);
         nextCycle();
      end
      applyStimulus(4'b0100, d, 1'b0, 1'b0);
      checkOutput("A stall 5", stallA, 16'd5);
      checkOutput("A accept 2", grantA, 2'd2);
      checkOutput("A held data", pushDataA, {2'd2, d[191:128]});
      nextCycle();

      // Asynchronous reset mid-cycle with source 3 presenting.
      d = {8{$urandom}};
      applyStimulus(4'b1000, d, 1'b0, 1'b0);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("A async rst push", pushA, 1'b0);
      checkOutput("A async rst ready", readyA, 4'b0);
      checkOutput("A async rst grant", grantA, 2'd0);
      ptrA = 0; ptrB = 0; stallModelA = 0; stallModelB = 0;
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(4'b1000, d, 1'b0, 1'b0);
      checkOutput("A post rst grant 3", grantA, 2'd3);
      nextCycle();
      applyStimulus(4'b1111, d, 1'b0, 1'b0);
      checkOutput("A ptr wrapped 0", grantA, 2'd0);
      nextCycle();

      // Randomised traffic respecting the hold-until-ready contract.
      doReset();
      for (int c = 0; c < 400; c++) begin
         v = validA;
         d = dataA;
         for (int i = 0; i < 4; i++) begin
            if (!pendA[i]) begin
               v[i] = ($urandom_range(0, 9) < 6);
               d[i*64 +: 64] = {$urandom, $urandom};
            end
         end
         applyStimulus(v, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
         nextCycle();
      end

      // Three sources: rotation 0,1,2,0 never touches index 3.
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulusB(3'b111, 24'h3C5A96, 1'b0, 1'b0);
         checkOutput("B rr seq", grantB, i % 3);
         nextCycle();
      end

      // Four-bit stall counter saturates at 15; clear wins over a stall cycle.
      doReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulusB(3'b001, 24'h0000E7, 1'b1, 1'b0);
         nextCycle();
      end
      applyStimulusB(3'b001, 24'h0000E7, 1'b1, 1'b0);
      checkOutput("B saturated", stallB, 4'd15);
      nextCycle();
      applyStimulusB(3'b001, 24'h0000E7, 1'b1, 1'b1);
      nextCycle();
      applyStimulusB(3'b001, 24'h0000E7, 1'b1, 1'b0);
      checkOutput("B cleared", stallB, 4'd0);
      nextCycle();
      applyStimulusB(3'b001, 24'h0000E7, 1'b0, 1'b0);
      checkOutput("B drain data", pushDataB, {2'd0, 8'hE7});
      nextCycle();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
